// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and slot-occupancy encoding for the pipeline stage register
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // The skid slot only ever fills behind a valid main slot.
  function automatic occ_e occupancy(input logic main_v, input logic skid_v);
    if (skid_v) return TWO;
    else if (main_v) return ONE;
    else return EMPTY;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+ctrl+data holding register; clearing zeroes ctrl but keeps data
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage with optional skid slot, flush and bubble counter
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              main_load;
  logic              main_clear;
  logic              skid_load;
  logic              skid_clear;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;
  logic              in_xfer;
  occ_e              occ;

  logic [CNT_W-1:0]  bubble_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_d;

  assign in_xfer = in_valid & in_ready;
  assign occ     = occupancy(main_valid, skid_valid);

  always_comb begin
    main_load   = 1'b0;
    main_clear  = 1'b0;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    main_ctrl_d = in_ctrl;
    main_data_d = in_data;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (occ)
        EMPTY: main_load = in_xfer;
        ONE: begin
          if (out_ready) begin
            main_load  = in_xfer;
            main_clear = !in_xfer;
          end else begin
            skid_load  = in_xfer;
          end
        end
        TWO: begin
          // in_ready is low here, so only the skid entry can advance.
          if (out_ready) begin
            main_load   = 1'b1;
            main_ctrl_d = skid_ctrl;
            main_data_d = skid_data;
            skid_clear  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (main_load),
    .clear_i (main_clear),
    .ctrl_i  (main_ctrl_d),
    .data_i  (main_data_d),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .ctrl_i  (in_ctrl),
      .data_i  (in_data),
      .valid_o (skid_valid),
      .ctrl_o  (skid_ctrl),
      .data_o  (skid_data)
    );
    assign in_ready = !skid_valid;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
    assign in_ready   = out_ready | !main_valid;
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (out_ready && !main_valid && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign out_valid  = main_valid;
  assign out_ctrl   = main_ctrl;
  assign out_data   = main_data;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for skid and single-entry pipeline stage variants
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;

  logic          clk;
  logic          reset;

  logic          in_valid, in_ready, out_valid, out_ready, flush;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] bubble_cnt;

  logic          z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_flush;
  logic [CW-1:0] z_in_ctrl, z_out_ctrl;
  logic [DW-1:0] z_in_data, z_out_data;
  logic [15:0]   z_bubble_cnt;

  int compared   = 0;
  int mismatched = 0;
  int exp_bub    = 0;
  int z_acc      = 0;

  logic [CW+DW-1:0] sb1[$];
  logic [CW+DW-1:0] sb0[$];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW), .SKID(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .flush(flush), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16), .SKID(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
    .flush(z_flush), .bubble_cnt(z_bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the skid DUT: record handshakes just before the edge, check after it.
  task automatic tick1();
    logic [CW+DW-1:0] e;
    #1;
    if (reset && out_valid && out_ready) begin
      compared++;
      assert (sb1.size() > 0) else begin
        mismatched++;
        $error("FAIL sb1_unexpected: observed %0h expected no output", out_data);
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        check("sb1_out", {out_ctrl, out_data}, e);
      end
    end
    if (reset && in_valid && in_ready && !flush) sb1.push_back({in_ctrl, in_data});
    if (reset && out_ready && !out_valid && exp_bub < 15) exp_bub++;
    if (!reset) begin
      sb1.delete();
      exp_bub = 0;
    end
    if (reset && flush) sb1.delete();
    @(negedge clk);
    check("bubble_cnt", bubble_cnt, exp_bub);
  endtask

  task automatic tick0();
    logic [CW+DW-1:0] e;
    #1;
    check("z_in_ready", z_in_ready, z_out_ready | !z_out_valid);
    if (z_out_valid && z_out_ready) begin
      compared++;
      assert (sb0.size() > 0) else begin
        mismatched++;
        $error("FAIL sb0_unexpected: observed %0h expected no output", z_out_data);
      end
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        check("sb0_out", {z_out_ctrl, z_out_data}, e);
      end
    end
    if (z_in_valid && z_in_ready) begin
      sb0.push_back({z_in_ctrl, z_in_data});
      z_acc++;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
    z_flush = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0; z_in_ctrl = '0; z_in_data = '0;
    @(negedge clk);
    tick1();
    reset = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_z_out_valid", z_out_valid, 0);
    check("rst_z_out_data", z_out_data, 0);
    check("rst_z_bubble", z_bubble_cnt, 0);
    check("rst_z_in_ready", z_in_ready, 1);

    // Back-to-back streaming at full rate.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = DW'(k);
      in_ctrl = CW'(k) | 8'h80;
      tick1();
      check("stream_in_ready", in_ready, 1);
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, k);
    end
    in_valid = 1'b0;
    tick1();
    check("stream_drained", out_valid, 0);

    // Stall with two entries held.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA; in_ctrl = 8'h11; tick1();
    in_data = 32'hB; in_ctrl = 8'h22; tick1();
    check("hold_in_ready", in_ready, 0);
    check("hold_valid", out_valid, 1);
    check("hold_data", out_data, 32'hA);
    in_data = 32'hEE; in_ctrl = 8'h33; tick1();
    check("hold_data2", out_data, 32'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    tick1();
    check("release_in_ready", in_ready, 1);
    check("release_data", out_data, 32'hB);
    tick1();
    check("release_empty", out_valid, 0);

    // Flush with both slots full.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF;
    in_data = 32'h21; tick1();
    in_data = 32'h22; tick1();
    check("full_in_ready", in_ready, 0);
    flush = 1'b1; in_data = 32'hC; in_ctrl = 8'h33;
    tick1();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, 0);
    check("flush_data_kept", out_data, 32'h21);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) tick1();
    check("flush_no_output", out_valid, 0);

    // Flush beats an input transfer while in_ready is high.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h31; in_ctrl = 8'h44;
    tick1();
    flush = 1'b1; in_data = 32'hC; in_ctrl = 8'h55;
    #1;
    check("flush_cycle_in_ready", in_ready, 1);
    tick1();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush2_valid", out_valid, 0);
    check("flush2_ctrl", out_ctrl, 0);
    repeat (2) tick1();
    check("flush2_no_output", out_valid, 0);

    // Bubble counter saturation.
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (20) tick1();
    check("bubble_sat", bubble_cnt, 15);

    // Reset mid-stream.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h66;
    in_data = 32'h51; tick1();
    in_data = 32'h52; tick1();
    reset = 1'b0; in_data = 32'h53;
    tick1();
    reset = 1'b1;
    check("mrst_valid", out_valid, 0);
    check("mrst_ctrl", out_ctrl, 0);
    check("mrst_data", out_data, 0);
    check("mrst_bubble", bubble_cnt, 0);
    check("mrst_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h05; out_ready = 1'b1;
    tick1();
    check("mrst_first_valid", out_valid, 1);
    check("mrst_first_data", out_data, 32'h77);
    in_valid = 1'b0;
    tick1();
    check("sb1_empty", sb1.size(), 0);

    // Single-entry variant with a toggling consumer.
    for (int i = 0; i < 400 && z_acc < 100; i++) begin
      z_in_valid  = 1'b1;
      z_in_data   = $urandom;
      z_in_ctrl   = CW'($urandom_range(1, 255));
      z_out_ready = (i % 2) == 0;
      tick0();
    end
    check("z_accepted", z_acc, 100);
    z_in_valid = 1'b0; z_out_ready = 1'b1;
    for (int i = 0; i < 10 && sb0.size() > 0; i++) tick0();
    check("sb0_empty", sb0.size(), 0);
    check("z_drained", z_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
